// File: rtl/writeback_unit_if.sv
// Retiring-instruction, load-response and register-file write bundle for writeback_unit.
// The writeback unit sits on the slave side; the pipeline/testbench drives the master side.
interface writeback_unit_if;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rd;
    logic [1:0]  in_wb_sel;
    logic [31:0] in_alu_result;
    logic [31:0] in_pc;
    logic [2:0]  in_funct3;
    logic [1:0]  in_addr_low;
    logic        dmem_rsp_valid;
    logic [31:0] dmem_rsp_data;
    logic [4:0]  addr_rd;
    logic [31:0] data_rd;
    logic        write_enable;
    logic [31:0] retire_count;
    logic        err_spurious;
    logic        err_timeout;

    modport slave (
        input  in_valid, in_rd, in_wb_sel, in_alu_result, in_pc, in_funct3, in_addr_low,
        input  dmem_rsp_valid, dmem_rsp_data,
        output in_ready, addr_rd, data_rd, write_enable, retire_count, err_spurious, err_timeout
    );

    modport master (
        output in_valid, in_rd, in_wb_sel, in_alu_result, in_pc, in_funct3, in_addr_low,
        output dmem_rsp_valid, dmem_rsp_data,
        input  in_ready, addr_rd, data_rd, write_enable, retire_count, err_spurious, err_timeout
    );
endinterface

// File: rtl/writeback_unit.sv
// Writeback stage: selects ALU / PC+4 / load data for the register file, waits for
// load responses with a timeout, counts retired instructions and keeps sticky error flags.
//
// state     | meaning
// IDLE      | accepting instructions; ALU/PC+4 results written one cycle later
// WAIT_LOAD | load issued, holding upstream until the response or the timeout
module writeback_unit #(
    parameter int LOAD_TIMEOUT = 16
) (
    input  logic             clock,
    input  logic             reset,
    writeback_unit_if.slave  wb
);
    typedef enum logic {IDLE, WAIT_LOAD} state_t;

    localparam logic [7:0] TIMER_TC = 8'(LOAD_TIMEOUT - 1);

    state_t      state;
    logic [4:0]  ld_rd;
    logic [2:0]  ld_funct3;
    logic [1:0]  ld_addr_low;
    logic [7:0]  timer;

    assign wb.in_ready = (state == IDLE);

    function automatic logic [31:0] extract(input logic [31:0] rsp,
                                            input logic [2:0]  funct3,
                                            input logic [1:0]  addr_low);
        logic [7:0]  b;
        logic [15:0] h;
        b = rsp[{addr_low, 3'b000} +: 8];
        h = rsp[{addr_low[1], 4'b0000} +: 16];
        case (funct3)
            3'b000:  extract = {{24{b[7]}}, b};
            3'b100:  extract = {24'd0, b};
            3'b001:  extract = {{16{h[15]}}, h};
            3'b101:  extract = {16'd0, h};
            3'b010:  extract = rsp;
            default: extract = 32'd0;
        endcase
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= IDLE;
            ld_rd           <= 5'd0;
            ld_funct3       <= 3'd0;
            ld_addr_low     <= 2'd0;
            timer           <= 8'd0;
            wb.addr_rd      <= 5'd0;
            wb.data_rd      <= 32'd0;
            wb.write_enable <= 1'b0;
            wb.retire_count <= 32'd0;
            wb.err_spurious <= 1'b0;
            wb.err_timeout  <= 1'b0;
        end else begin
            wb.write_enable <= 1'b0;
            case (state)
                IDLE: begin
                    // A response with no load outstanding is never written back.
                    if (wb.dmem_rsp_valid)
                        wb.err_spurious <= 1'b1;
                    if (wb.in_valid) begin
                        case (wb.in_wb_sel)
                            2'd0, 2'd2: begin
                                wb.retire_count <= wb.retire_count + 32'd1;
                                if (wb.in_rd != 5'd0) begin
                                    wb.write_enable <= 1'b1;
                                    wb.addr_rd      <= wb.in_rd;
                                    wb.data_rd      <= (wb.in_wb_sel == 2'd0) ? wb.in_alu_result
                                                                              : wb.in_pc + 32'd4;
                                end
                            end
                            2'd1: begin
                                ld_rd       <= wb.in_rd;
                                ld_funct3   <= wb.in_funct3;
                                ld_addr_low <= wb.in_addr_low;
                                timer       <= 8'd0;
                                state       <= WAIT_LOAD;
                            end
                            default: wb.retire_count <= wb.retire_count + 32'd1;
                        endcase
                    end
                end
                WAIT_LOAD: begin
                    // Response is checked first so it wins over a coincident timeout.
                    if (wb.dmem_rsp_valid) begin
                        wb.retire_count <= wb.retire_count + 32'd1;
                        if (ld_rd != 5'd0) begin
                            wb.write_enable <= 1'b1;
                            wb.addr_rd      <= ld_rd;
                            wb.data_rd      <= extract(wb.dmem_rsp_data, ld_funct3, ld_addr_low);
                        end
                        timer <= 8'd0;
                        state <= IDLE;
                    end else if (timer == TIMER_TC) begin
                        wb.err_timeout <= 1'b1;
                        timer          <= 8'd0;
                        state          <= IDLE;
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_writeback_unit.sv
// Bench for writeback_unit: directed literal cases plus randomized traffic against
// a behavioural model, compared on every falling edge.
module tb_writeback_unit;
    localparam int TMO = 16;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    writeback_unit_if bus();

    writeback_unit #(.LOAD_TIMEOUT(TMO)) dut (
        .clock (clock),
        .reset (reset),
        .wb    (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Load data selection written as shifts and masks rather than part-selects.
    function automatic logic [31:0] ref_extract(input logic [31:0] rsp, input int f3, input int al);
        logic [31:0] b, h;
        b = (rsp >> (8 * al)) & 32'h0000_00FF;
        h = (rsp >> (16 * (al / 2))) & 32'h0000_FFFF;
        case (f3)
            0:       return (b >= 32'd128)   ? b + 32'hFFFF_FF00 : b;
            4:       return b;
            1:       return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
            5:       return h;
            2:       return rsp;
            default: return 32'd0;
        endcase
    endfunction

    bit          m_live = 1'b0;
    bit          m_pending = 1'b0;
    int          m_waited = 0;
    int          m_rd = 0, m_f3 = 0, m_al = 0;
    bit          m_we = 1'b0;
    logic [4:0]  m_addr = '0;
    logic [31:0] m_data = '0;
    logic [31:0] m_cnt = '0;
    bit          m_sp = 1'b0, m_to = 1'b0;

    always @(posedge clock) begin
        if (reset) begin
            m_live = 1'b1; m_pending = 1'b0; m_waited = 0;
            m_we = 1'b0; m_addr = '0; m_data = '0; m_cnt = '0; m_sp = 1'b0; m_to = 1'b0;
        end else if (m_live) begin
            m_we = 1'b0;
            if (!m_pending) begin
                if (bus.dmem_rsp_valid) m_sp = 1'b1;
                if (bus.in_valid) begin
                    if (bus.in_wb_sel == 2'd1) begin
                        m_pending = 1'b1; m_waited = 0;
                        m_rd = int'(bus.in_rd); m_f3 = int'(bus.in_funct3); m_al = int'(bus.in_addr_low);
                    end else begin
                        m_cnt = m_cnt + 1;
                        if (bus.in_wb_sel != 2'd3 && bus.in_rd != 0) begin
                            m_we = 1'b1; m_addr = bus.in_rd;
                            m_data = (bus.in_wb_sel == 2'd0) ? bus.in_alu_result : bus.in_pc + 4;
                        end
                    end
                end
            end else begin
                m_waited++;
                if (bus.dmem_rsp_valid) begin
                    m_pending = 1'b0; m_cnt = m_cnt + 1;
                    if (m_rd != 0) begin
                        m_we = 1'b1; m_addr = 5'(m_rd);
                        m_data = ref_extract(bus.dmem_rsp_data, m_f3, m_al);
                    end
                end else if (m_waited == TMO) begin
                    m_pending = 1'b0; m_to = 1'b1;
                end
            end
        end
    end

    always @(negedge clock) begin
        if (m_live && !reset) begin
            chk("in_ready", 32'(bus.in_ready), 32'(!m_pending));
            chk("write_enable", 32'(bus.write_enable), 32'(m_we));
            chk("retire_count", bus.retire_count, m_cnt);
            chk("err_spurious", 32'(bus.err_spurious), 32'(m_sp));
            chk("err_timeout", 32'(bus.err_timeout), 32'(m_to));
            if (m_we) begin
                chk("addr_rd", 32'(bus.addr_rd), 32'(m_addr));
                chk("data_rd", bus.data_rd, m_data);
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input int sel, input int rd, input logic [31:0] alu, input logic [31:0] pc,
                         input int f3, input int al);
        bus.in_valid = 1'b1; bus.in_wb_sel = 2'(sel); bus.in_rd = 5'(rd);
        bus.in_alu_result = alu; bus.in_pc = pc; bus.in_funct3 = 3'(f3); bus.in_addr_low = 2'(al);
    endtask

    // Load through two waiting cycles, response arriving in the third.
    task automatic load_case(input string name, input int f3, input int al,
                             input logic [31:0] rsp, input logic [31:0] exp_data);
        issue(1, 7, 32'd0, 32'd0, f3, al);
        step();
        bus.in_valid = 1'b0;
        chk({name, "_ready0"}, 32'(bus.in_ready), 32'd0);
        step();
        chk({name, "_ready1"}, 32'(bus.in_ready), 32'd0);
        step();
        chk({name, "_ready2"}, 32'(bus.in_ready), 32'd0);
        bus.dmem_rsp_valid = 1'b1; bus.dmem_rsp_data = rsp;
        step();
        bus.dmem_rsp_valid = 1'b0;
        chk({name, "_we"}, 32'(bus.write_enable), 32'd1);
        chk({name, "_addr"}, 32'(bus.addr_rd), 32'd7);
        chk({name, "_data"}, bus.data_rd, exp_data);
    endtask

    initial begin
        int pct;
        bus.in_valid = 1'b0; bus.in_rd = '0; bus.in_wb_sel = '0; bus.in_alu_result = '0;
        bus.in_pc = '0; bus.in_funct3 = '0; bus.in_addr_low = '0;
        bus.dmem_rsp_valid = 1'b0; bus.dmem_rsp_data = '0;
        step(); step();
        reset = 1'b0;
        chk("rst_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_we", 32'(bus.write_enable), 32'd0);
        chk("rst_data", bus.data_rd, 32'd0);
        chk("rst_count", bus.retire_count, 32'd0);

        issue(0, 5, 32'h0000_1234, 32'd0, 0, 0);
        step();
        chk("alu1_we", 32'(bus.write_enable), 32'd1);
        chk("alu1_addr", 32'(bus.addr_rd), 32'd5);
        chk("alu1_data", bus.data_rd, 32'h0000_1234);
        issue(0, 6, 32'hFFFF_FFFF, 32'd0, 0, 0);
        step();
        bus.in_valid = 1'b0;
        chk("alu2_we", 32'(bus.write_enable), 32'd1);
        chk("alu2_addr", 32'(bus.addr_rd), 32'd6);
        chk("alu2_data", bus.data_rd, 32'hFFFF_FFFF);
        chk("alu_count", bus.retire_count, 32'd2);
        step();
        chk("alu_we_pulse", 32'(bus.write_enable), 32'd0);

        load_case("lb", 0, 3, 32'h80AB_CDEF, 32'hFFFF_FF80);
        load_case("lbu", 4, 3, 32'h80AB_CDEF, 32'h0000_0080);
        load_case("lh", 1, 2, 32'h8001_7FFF, 32'hFFFF_8001);
        load_case("lw", 2, 2, 32'h8001_7FFF, 32'h8001_7FFF);
        chk("load_count", bus.retire_count, 32'd6);

        issue(2, 0, 32'd0, 32'h0000_0100, 0, 0);
        step();
        bus.in_valid = 1'b0;
        chk("rd0_we", 32'(bus.write_enable), 32'd0);
        chk("rd0_count", bus.retire_count, 32'd7);

        issue(1, 3, 32'd0, 32'd0, 2, 0);
        step();
        bus.in_valid = 1'b0;
        for (int i = 0; i < TMO - 1; i++) step();
        chk("tmo_not_yet", 32'(bus.err_timeout), 32'd0);
        chk("tmo_still_wait", 32'(bus.in_ready), 32'd0);
        step();
        chk("tmo_flag", 32'(bus.err_timeout), 32'd1);
        chk("tmo_idle", 32'(bus.in_ready), 32'd1);
        chk("tmo_no_we", 32'(bus.write_enable), 32'd0);
        chk("tmo_count", bus.retire_count, 32'd7);
        bus.dmem_rsp_valid = 1'b1; bus.dmem_rsp_data = 32'h1111_2222;
        step();
        bus.dmem_rsp_valid = 1'b0;
        chk("spur_flag", 32'(bus.err_spurious), 32'd1);
        chk("spur_no_we", 32'(bus.write_enable), 32'd0);

        issue(1, 9, 32'd0, 32'd0, 2, 0);
        step();
        bus.in_valid = 1'b0;
        reset = 1'b1; bus.dmem_rsp_valid = 1'b1; bus.dmem_rsp_data = 32'hDEAD_BEEF;
        step();
        reset = 1'b0; bus.dmem_rsp_valid = 1'b0;
        chk("rstld_we", 32'(bus.write_enable), 32'd0);
        chk("rstld_addr", 32'(bus.addr_rd), 32'd0);
        chk("rstld_data", bus.data_rd, 32'd0);
        chk("rstld_count", bus.retire_count, 32'd0);
        chk("rstld_errs", 32'({bus.err_spurious, bus.err_timeout}), 32'd0);
        chk("rstld_ready", 32'(bus.in_ready), 32'd1);

        issue(1, 4, 32'd0, 32'd0, 2, 0);
        step();
        bus.in_valid = 1'b0;
        for (int i = 0; i < TMO - 1; i++) step();
        bus.dmem_rsp_valid = 1'b1; bus.dmem_rsp_data = 32'hCAFE_F00D;
        step();
        bus.dmem_rsp_valid = 1'b0;
        chk("edge_we", 32'(bus.write_enable), 32'd1);
        chk("edge_data", bus.data_rd, 32'hCAFE_F00D);
        chk("edge_no_tmo", 32'(bus.err_timeout), 32'd0);
        chk("edge_count", bus.retire_count, 32'd1);

        pct = 30;
        for (int c = 0; c < 4000; c++) begin
            if (c % 200 == 0) begin
                case ($urandom_range(0, 2))
                    0: pct = 2;
                    1: pct = 15;
                    default: pct = 45;
                endcase
            end
            reset              = ($urandom_range(0, 299) == 0);
            bus.in_valid       = ($urandom_range(0, 99) < 60);
            bus.in_wb_sel      = 2'($urandom_range(0, 3));
            bus.in_rd          = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            bus.in_alu_result  = $urandom;
            bus.in_pc          = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : $urandom;
            bus.in_funct3      = 3'($urandom_range(0, 7));
            bus.in_addr_low    = 2'($urandom_range(0, 3));
            bus.dmem_rsp_valid = ($urandom_range(0, 99) < pct);
            bus.dmem_rsp_data  = $urandom;
            step();
        end
        reset = 1'b0; bus.in_valid = 1'b0; bus.dmem_rsp_valid = 1'b0;
        step(); step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/writeback_unit.md
WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 SHALL have parameter: LOAD_TIMEOUT, 16, max cycles spent in WAIT_LOAD before abandoning the load (range 1..255).
REQ-002 SHALL have port: clock  in  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port: reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port: in_valid  in  1  memory stage presents a retiring instruction.
REQ-005 SHALL have port: in_ready  out  1  unit accepts the instruction this cycle.
REQ-006 SHALL have port: in_rd  in  5  destination register index.
REQ-007 SHALL have port: in_wb_sel  in  2  source select: 0 = ALU, 1 = load, 2 = PC+4, 3 = no write.
REQ-008 SHALL have ports: in_alu_result  in  32 and in_pc  in  32.
REQ-009 SHALL have ports: in_funct3  in  3 (load size/sign) and in_addr_low  in  2 (byte offset of load address).
REQ-010 SHALL have ports: dmem_rsp_valid  in  1 and dmem_rsp_data  in  32  data memory load response.
REQ-011 SHALL have ports driving the register file write port: addr_rd  out  5, data_rd  out  32, write_enable  out  1.
REQ-012 SHALL have ports: retire_count  out  32  retired instructions; err_spurious  out  1 and err_timeout  out  1  sticky error flags.

Function
REQ-013 SHALL implement FSM states IDLE and WAIT_LOAD.
REQ-014 SHALL drive in_ready = 1 in IDLE and 0 in WAIT_LOAD (combinational from state).
REQ-015 SHALL register addr_rd, data_rd and write_enable; write_enable SHALL be a single-cycle pulse per write.
REQ-016 IDLE with in_valid and in_wb_sel 0 or 2: next edge SHALL set addr_rd = in_rd, data_rd = in_alu_result (sel 0) or in_pc + 4 mod 2^32 (sel 2), write_enable = 1; state stays IDLE, giving 1-cycle latency and back-to-back acceptance.
REQ-017 IDLE with in_valid and in_wb_sel 3: no write; the instruction SHALL still retire.
REQ-018 IDLE with in_valid and in_wb_sel 1: SHALL latch in_rd, in_funct3 and in_addr_low, clear the timeout counter, and enter WAIT_LOAD; write_enable = 0 on the next cycle.
REQ-019 WAIT_LOAD with dmem_rsp_valid: next edge SHALL write the extracted data to the latched rd with write_enable = 1 and return to IDLE.
REQ-020 Extraction rules: byte = rsp[8*addr_low +: 8]; half = rsp[16*addr_low[1] +: 16]; funct3 000 sign-extends byte, 100 zero-extends byte, 001 sign-extends half, 101 zero-extends half, 010 takes the full word; any other funct3 yields 0.
REQ-021 If rd = 0, write_enable SHALL remain 0, but the instruction SHALL still retire.
REQ-022 retire_count SHALL increment by 1, wrapping at 2^32, on each edge where an instruction completes (REQ-016, REQ-017, REQ-019, REQ-021).
REQ-023 WAIT_LOAD SHALL count cycles; if LOAD_TIMEOUT cycles elapse without dmem_rsp_valid, it SHALL set err_timeout, return to IDLE, not write, and not retire.
REQ-024 dmem_rsp_valid in IDLE SHALL be ignored for writeback and SHALL set err_spurious, even when in_valid is high in the same cycle.
REQ-025 dmem_rsp_valid arriving in the same cycle the timeout expires SHALL win: the write proceeds and err_timeout stays unchanged.
REQ-026 in_valid while in_ready = 0 SHALL be ignored; the upstream stage holds.
REQ-027 Sticky errors SHALL clear only on reset.

Reset
REQ-028 Reset SHALL force: state IDLE, write_enable 0, addr_rd 0, data_rd 0, retire_count 0, err_spurious 0, err_timeout 0, timeout counter 0.
REQ-029 Reset asserted in WAIT_LOAD SHALL discard the pending load; a response arriving in the same cycle SHALL NOT be written.
REQ-030 in_valid and dmem_rsp_valid SHALL be ignored while reset is high.

Verification
REQ-031 ALU back-to-back: sel 0, rd 5, 0x0000_1234, then rd 6, 0xFFFF_FFFF on consecutive cycles -> two consecutive write_enable pulses with matching addr/data; retire_count = 2.
REQ-032 Load lb: rd 7, funct3 000, addr_low 3, response 0x80AB_CDEF after 3 cycles -> in_ready low for those 3 cycles, then data_rd 0xFFFF_FF80; the same case with funct3 100 -> 0x0000_0080.
REQ-033 Load lh: addr_low 2, response 0x8001_7FFF -> data_rd 0xFFFF_8001; lw -> 0x8001_7FFF.
REQ-034 rd = 0 with sel 2, pc 0x100 -> write_enable stays 0 and retire_count increments.
REQ-035 Timeout: load with no response for 16 cycles -> err_timeout = 1, IDLE, no write; a subsequent response -> err_spurious = 1.
REQ-036 Reset mid-load: reset raised in WAIT_LOAD with a coincident response -> no write, all outputs 0, in_ready = 1 after reset deasserts.
